// File: rtl/tmr_pkg.sv
// Shared constants for the 8-bit timer: counter width and wrap endpoints.
package tmr_pkg;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] TCNT_MAX = 8'hFF;
  localparam logic [WIDTH-1:0] TCNT_MIN = 8'h00;
endpackage

// File: rtl/tmr_sticky_flag.sv
// Sticky status flag: set has priority over clear, cleared by async reset.
module tmr_sticky_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic flag
);

  // Set wins over a same-edge clear so a wrap event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (set) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/tmr_counter.sv
// 8-bit up/down timer counter (TCNT) with load and sticky wrap flags.
module tmr_counter
  import tmr_pkg::*;
#(
  parameter int WIDTH = tmr_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] start_counter,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] reg_TCNT;
  logic             step;
  logic             wrap_up;
  logic             wrap_dn;

  // A counting step happens only on an enabled tick that is not overridden by a load.
  assign step    = enable & clk_ena & ~load;
  assign wrap_up = step &  up_down & (reg_TCNT == WIDTH'(TCNT_MAX));
  assign wrap_dn = step & ~up_down & (reg_TCNT == WIDTH'(TCNT_MIN));

  // Counter register: load beats counting; direction is sampled at the tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_TCNT <= '0;
    end else if (load) begin
      reg_TCNT <= start_counter;
    end else if (enable && clk_ena) begin
      if (up_down) begin
        reg_TCNT <= reg_TCNT + 1'b1;
      end else begin
        reg_TCNT <= reg_TCNT - 1'b1;
      end
    end
  end

  tmr_sticky_flag u_overflow (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (wrap_up),
    .clr   (clr_overflow),
    .flag  (overflow)
  );

  tmr_sticky_flag u_underflow (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (wrap_dn),
    .clr   (clr_underflow),
    .flag  (underflow)
  );

endmodule

// File: tb/tb_tmr_counter.sv
// Directed testbench for tmr_counter: reset, wrap flags, clears, enable, async reset.
module tb_tmr_counter;

  logic       clk;
  logic       rst_n;
  logic       clk_ena;
  logic [7:0] start_counter;
  logic       up_down;
  logic       load;
  logic       enable;
  logic       clr_overflow;
  logic       clr_underflow;
  logic       overflow;
  logic       underflow;

  int n_checks;
  int n_fail;

  tmr_counter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_ena       (clk_ena),
    .start_counter (start_counter),
    .up_down       (up_down),
    .load          (load),
    .enable        (enable),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; drive and sample 1 time unit after it.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_ena = 1'b0; start_counter = 8'h00; up_down = 1'b0;
    load = 1'b0; enable = 1'b0; clr_overflow = 1'b0; clr_underflow = 1'b0;
    repeat (5) step_clk();
    rst_n = 1'b1;
    step_clk();
    n_checks++;
    if (dut.reg_TCNT !== 8'h00) begin
      $display("FAIL reset_tcnt: got %h expected %h", dut.reg_TCNT, 8'h00); n_fail++;
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL reset_ovf: got %b expected 0", overflow); n_fail++;
    end
    n_checks++;
    if (underflow !== 1'b0) begin
      $display("FAIL reset_unf: got %b expected 0", underflow); n_fail++;
    end
  endtask

  task automatic test_overflow();
    int early_flag;
    early_flag = 0;
    enable = 1'b1; up_down = 1'b1; start_counter = 8'd10; load = 1'b1; clk_ena = 1'b1;
    step_clk();
    load = 1'b0; clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'd10) begin
      $display("FAIL load_in_tick: got %h expected %h", dut.reg_TCNT, 8'd10); n_fail++;
    end
    for (int k = 1; k <= 245; k++) begin
      clk_ena = 1'b1;
      step_clk();
      clk_ena = 1'b0;
      if (overflow !== 1'b0 || underflow !== 1'b0) early_flag++;
      step_clk();
    end
    n_checks++;
    if (early_flag !== 0) begin
      $display("FAIL no_early_flag: got %0d flagged ticks expected 0", early_flag); n_fail++;
    end
    n_checks++;
    if (dut.reg_TCNT !== 8'hFF) begin
      $display("FAIL tick245_tcnt: got %h expected %h", dut.reg_TCNT, 8'hFF); n_fail++;
    end
    clk_ena = 1'b1;
    step_clk();
    clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'h00) begin
      $display("FAIL tick246_tcnt: got %h expected %h", dut.reg_TCNT, 8'h00); n_fail++;
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL tick246_ovf: got %b expected 1", overflow); n_fail++;
    end
    n_checks++;
    if (underflow !== 1'b0) begin
      $display("FAIL tick246_unf: got %b expected 0", underflow); n_fail++;
    end
    step_clk();
    n_checks++;
    if (dut.reg_TCNT !== 8'h00 || overflow !== 1'b1) begin
      $display("FAIL hold_no_tick: got tcnt=%h ovf=%b expected tcnt=00 ovf=1", dut.reg_TCNT, overflow); n_fail++;
    end
  endtask

  task automatic test_clear_overflow();
    clr_overflow = 1'b1;
    step_clk();
    clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL clr_ovf: got %b expected 0", overflow); n_fail++;
    end
    load = 1'b1; start_counter = 8'hFF;
    step_clk();
    load = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'hFF || overflow !== 1'b0) begin
      $display("FAIL load_ff_noflag: got tcnt=%h ovf=%b expected tcnt=ff ovf=0", dut.reg_TCNT, overflow); n_fail++;
    end
    clr_overflow = 1'b1; clk_ena = 1'b1; up_down = 1'b1;
    step_clk();
    clr_overflow = 1'b0; clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'h00 || overflow !== 1'b1) begin
      $display("FAIL set_beats_clr: got tcnt=%h ovf=%b expected tcnt=00 ovf=1", dut.reg_TCNT, overflow); n_fail++;
    end
    clr_overflow = 1'b1;
    step_clk();
    clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL clr_ovf_again: got %b expected 0", overflow); n_fail++;
    end
  endtask

  task automatic test_underflow();
    load = 1'b1; start_counter = 8'd5; up_down = 1'b0; enable = 1'b1;
    step_clk();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      clk_ena = 1'b1;
      step_clk();
      clk_ena = 1'b0;
      step_clk();
    end
    n_checks++;
    if (dut.reg_TCNT !== 8'h00 || underflow !== 1'b0) begin
      $display("FAIL down5: got tcnt=%h unf=%b expected tcnt=00 unf=0", dut.reg_TCNT, underflow); n_fail++;
    end
    clk_ena = 1'b1;
    step_clk();
    clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'hFF) begin
      $display("FAIL down6_tcnt: got %h expected %h", dut.reg_TCNT, 8'hFF); n_fail++;
    end
    n_checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL down6_flags: got unf=%b ovf=%b expected unf=1 ovf=0", underflow, overflow); n_fail++;
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; clk_ena = 1'b1; up_down = 1'b1;
    repeat (4) step_clk();
    n_checks++;
    if (dut.reg_TCNT !== 8'hFF || underflow !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL disabled_hold: got tcnt=%h unf=%b ovf=%b expected tcnt=ff unf=1 ovf=0", dut.reg_TCNT, underflow, overflow); n_fail++;
    end
    clr_underflow = 1'b1;
    step_clk();
    clr_underflow = 1'b0;
    n_checks++;
    if (underflow !== 1'b0) begin
      $display("FAIL clr_unf_disabled: got %b expected 0", underflow); n_fail++;
    end
    load = 1'b1; start_counter = 8'h5A;
    step_clk();
    load = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'h5A) begin
      $display("FAIL load_disabled: got %h expected %h", dut.reg_TCNT, 8'h5A); n_fail++;
    end
    enable = 1'b1; up_down = 1'b1;
    step_clk();
    n_checks++;
    if (dut.reg_TCNT !== 8'h5B) begin
      $display("FAIL resume_up: got %h expected %h", dut.reg_TCNT, 8'h5B); n_fail++;
    end
    up_down = 1'b0;
    step_clk();
    clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'h5A) begin
      $display("FAIL dir_change: got %h expected %h", dut.reg_TCNT, 8'h5A); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; up_down = 1'b1; load = 1'b1; start_counter = 8'hFF;
    step_clk();
    load = 1'b0; clk_ena = 1'b1;
    repeat (3) step_clk();
    clk_ena = 1'b0;
    n_checks++;
    if (dut.reg_TCNT !== 8'h02 || overflow !== 1'b1) begin
      $display("FAIL pre_reset: got tcnt=%h ovf=%b expected tcnt=02 ovf=1", dut.reg_TCNT, overflow); n_fail++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut.reg_TCNT !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL async_reset: got tcnt=%h ovf=%b unf=%b expected all 0", dut.reg_TCNT, overflow, underflow); n_fail++;
    end
    #2;
    rst_n = 1'b1;
    step_clk();
    n_checks++;
    if (dut.reg_TCNT !== 8'h00 || overflow !== 1'b0) begin
      $display("FAIL post_reset: got tcnt=%h ovf=%b expected tcnt=00 ovf=0", dut.reg_TCNT, overflow); n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_overflow();
    test_clear_overflow();
    test_underflow();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
